// File: rtl/capture_packet_tx.sv
// Drains 16-bit words from the capture transfer FIFO and frames them into a
// byte packet (header, payload, count, checksum, footer) for the UART.
`timescale 1ns/1ps
module capture_packet_tx #(
    parameter int         MAX_WORDS     = 128,
    parameter int         EMPTY_TIMEOUT = 16,
    parameter logic [7:0] HEADER_BYTE   = 8'hA5,
    parameter logic [7:0] FOOTER_BYTE   = 8'h5A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dataReadyToRead,
    input  logic        dataValid,
    input  logic [15:0] dataOut,
    output logic        dataRead,
    output logic        readyToTransmit,
    input  logic        txBusy,
    output logic        txStart,
    output logic [7:0]  txData,
    output logic        packetActive
);

    typedef enum logic [9:0] {
        IDLE       = 10'b00_0000_0001,
        HDR        = 10'b00_0000_0010,
        FETCH      = 10'b00_0000_0100,
        WAIT_VALID = 10'b00_0000_1000,
        SEND_HI    = 10'b00_0001_0000,
        SEND_LO    = 10'b00_0010_0000,
        GAP        = 10'b00_0100_0000,
        SEND_CNT   = 10'b00_1000_0000,
        SEND_SUM   = 10'b01_0000_0000,
        SEND_FTR   = 10'b10_0000_0000
    } state_t;

    state_t      state_reg;
    logic [1:0]  phase_reg;
    logic [15:0] word_reg;
    logic [7:0]  count_reg;
    logic [7:0]  gap_reg;
    logic [7:0]  sum_reg;
    logic        read_reg;
    logic        ready_reg;
    logic        start_reg;
    logic [7:0]  data_reg;
    logic        active_reg;

    logic [7:0]  tx_byte;
    logic        is_send;
    logic        accept;
    logic [7:0]  count_inc;

    assign dataRead        = read_reg;
    assign readyToTransmit = ready_reg;
    assign txStart         = start_reg;
    assign txData          = data_reg;
    assign packetActive    = active_reg;

    always_comb begin
        tx_byte = 8'h00;
        is_send = 1'b1;
        case (state_reg)
            HDR:      tx_byte = HEADER_BYTE;
            SEND_HI:  tx_byte = word_reg[15:8];
            SEND_LO:  tx_byte = word_reg[7:0];
            SEND_CNT: tx_byte = count_reg;
            SEND_SUM: tx_byte = sum_reg;
            SEND_FTR: tx_byte = FOOTER_BYTE;
            default:  is_send = 1'b0;
        endcase
    end

    // Phase 0: wait idle and pulse; 1: UART still latching, busy ignored; 2: wait done.
    assign accept    = is_send && (phase_reg == 2'd2) && !txBusy;
    assign count_inc = count_reg + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            phase_reg  <= 2'd0;
            word_reg   <= 16'h0000;
            count_reg  <= 8'h00;
            gap_reg    <= 8'h00;
            sum_reg    <= 8'h00;
            read_reg   <= 1'b0;
            ready_reg  <= 1'b0;
            start_reg  <= 1'b0;
            data_reg   <= 8'h00;
            active_reg <= 1'b0;
        end else begin
            read_reg  <= 1'b0;
            start_reg <= 1'b0;

            if (is_send) begin
                case (phase_reg)
                    2'd0: if (!txBusy) begin
                        start_reg <= 1'b1;
                        data_reg  <= tx_byte;
                        phase_reg <= 2'd1;
                    end
                    2'd1: phase_reg <= 2'd2;
                    default: if (!txBusy) phase_reg <= 2'd0;
                endcase
            end

            case (state_reg)
                IDLE: begin
                    ready_reg <= 1'b1;
                    if (dataReadyToRead && !txBusy) begin
                        state_reg  <= HDR;
                        ready_reg  <= 1'b0;
                        active_reg <= 1'b1;
                        count_reg  <= 8'h00;
                        gap_reg    <= 8'h00;
                        sum_reg    <= 8'h00;
                    end
                end
                HDR: if (accept) state_reg <= FETCH;
                FETCH: begin
                    read_reg  <= 1'b1;
                    state_reg <= WAIT_VALID;
                end
                WAIT_VALID: if (dataValid) begin
                    word_reg  <= dataOut;
                    state_reg <= SEND_HI;
                end
                SEND_HI: if (accept) begin
                    sum_reg   <= sum_reg + tx_byte;
                    state_reg <= SEND_LO;
                end
                SEND_LO: if (accept) begin
                    sum_reg   <= sum_reg + tx_byte;
                    count_reg <= count_inc;
                    gap_reg   <= 8'h00;
                    if (count_inc == 8'(MAX_WORDS))
                        state_reg <= SEND_CNT;
                    else if (dataReadyToRead)
                        state_reg <= FETCH;
                    else
                        state_reg <= GAP;
                end
                GAP: begin
                    // An expired timeout wins over data arriving in the same cycle.
                    if (gap_reg == 8'(EMPTY_TIMEOUT)) begin
                        state_reg <= SEND_CNT;
                    end else if (dataReadyToRead) begin
                        state_reg <= FETCH;
                        gap_reg   <= 8'h00;
                    end else begin
                        gap_reg <= gap_reg + 8'd1;
                    end
                end
                SEND_CNT: if (accept) begin
                    sum_reg   <= sum_reg + tx_byte;
                    state_reg <= SEND_SUM;
                end
                SEND_SUM: if (accept) state_reg <= SEND_FTR;
                SEND_FTR: if (accept) begin
                    state_reg  <= IDLE;
                    active_reg <= 1'b0;
                    ready_reg  <= 1'b1;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/capture_packet_tx.md
Name: capture_packet_tx

Overview:
- Downstream consumer of the capture/accumulate block's 16-bit transfer FIFO, running in that FIFO's read clock domain.
- Drains accumulated words, frames them into a byte packet (header, payload, count, checksum, footer) and hands bytes one at a time to the UART transmitter.
- Drives the readyToTransmit handshake back to the capture block, so the accumulator only empties into the transfer FIFO while this block is idle and able to ship the data.

Parameters:
- MAX_WORDS, 128, maximum payload words per packet; legal range 1..255.
- EMPTY_TIMEOUT, 16, consecutive cycles with dataReadyToRead low after a word that close the packet; legal range 1..255.
- HEADER_BYTE, 8'hA5, first byte of every packet.
- FOOTER_BYTE, 8'h5A, last byte of every packet.

Ports:
- clk  in  1  block clock (the capture block's slow clock); all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- dataReadyToRead  in  1  transfer FIFO not empty.
- dataValid  in  1  transfer FIFO read data valid.
- dataOut  in  16  transfer FIFO read data.
- dataRead  out  1  transfer FIFO read enable; single-cycle pulse.
- readyToTransmit  out  1  high while the block is idle and able to accept a packet.
- txBusy  in  1  UART transmitter busy.
- txStart  out  1  one-cycle pulse; UART latches txData on this pulse.
- txData  out  8  byte to transmit.
- packetActive  out  1  high from leaving IDLE until the footer byte is accepted.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, sampled on posedge clk.
- Reset values: dataRead=0, txStart=0, txData=8'h00, packetActive=0, readyToTransmit=0 during reset and 1 from the first cycle after it. State=IDLE; word counter, gap counter and checksum are all 0.
- Reset mid-packet: all outputs take their reset values on the next edge. Any partially sent packet is abandoned, with no footer. FIFO contents are not touched.
- State machine (one-hot): IDLE, HDR, FETCH, WAIT_VALID, SEND_HI, SEND_LO, GAP, SEND_CNT, SEND_SUM, SEND_FTR.
- Byte send rule (every SEND_*/HDR state):
  - When txBusy=0 and no send is pending, drive txStart=1 for exactly one cycle with txData set to the byte.
  - The cycle after txStart, txBusy is ignored.
  - From the second cycle after txStart, advance when txBusy=0.
  - Minimum 2 cycles per byte. txData holds its value until the next txStart.
- IDLE: readyToTransmit=1. Leave to HDR when dataReadyToRead=1 and txBusy=0; clear counters and checksum.
- HDR: send HEADER_BYTE, then go to FETCH. The header is not included in the checksum.
- FETCH: pulse dataRead for 1 cycle, then go to WAIT_VALID. Only one read is outstanding at any time.
- WAIT_VALID: on dataValid=1, capture dataOut into a 16-bit holding register and go to SEND_HI. Wait indefinitely.
- SEND_HI / SEND_LO: send word[15:8], then word[7:0]. Each accepted payload byte is added to the checksum (8-bit, mod 256). After SEND_LO, the word counter increments.
- After a word:
  - If count == MAX_WORDS, go to SEND_CNT.
  - Else if dataReadyToRead=1, go to FETCH.
  - Else go to GAP.
- GAP: gap counter increments every cycle that dataReadyToRead=0.
  - If dataReadyToRead=1, go to FETCH and clear the gap counter.
  - When the gap counter reaches EMPTY_TIMEOUT, go to SEND_CNT.
- SEND_CNT: send word count (8 bits, 1..MAX_WORDS), added to the checksum.
- SEND_SUM: send the checksum byte.
- SEND_FTR: send FOOTER_BYTE, then return to IDLE.
- Packet format: A5, {hi, lo} × N, N, sum(payload bytes, N) mod 256, 5A.
- Simultaneous events: dataReadyToRead rising on the same cycle the GAP timeout expires closes the packet; the new data starts the next packet.
- Words remaining in the FIFO after MAX_WORDS are sent in the next packet.

Test Plan:
- Reset, idle: after reset -> readyToTransmit=1, txStart=0, dataRead=0, packetActive=0.
- Single word: FIFO holds 16'h1234, UART ideal (busy 3 cycles) -> bytes A5 12 34 01 47 5A; exactly one dataRead pulse.
- Checksum wrap: words 16'hFFFF and 16'h0102 -> payload FF FF 01 02, count 02, checksum (FF+FF+01+02+02) mod 256 = 03; footer 5A.
- MAX_WORDS split: MAX_WORDS=4, 6 words queued -> first packet count=04, second packet count=02; 6 total dataRead pulses; no data loss or duplication.
- Gap: second word appears 10 cycles after the first word is sent (EMPTY_TIMEOUT=16) -> one packet, count 02. Second word appears 20 cycles later -> two packets, count 01 each.
- Reset mid-packet: assert rst during SEND_LO -> next cycle txStart=0, packetActive=0. After release, a new packet starts with A5; the FIFO word count is unchanged by reset.
